// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
//   Shared definitions for the parametrised accumulator slice.
//   - acc_mode_t : 2-bit operation selector presented on acc_param.mode
//   - ACC_ADD / ACC_SUB / ACC_LOAD / ACC_HOLD : encodings of acc_mode_t
// -----------------------------------------------------------------------------
package acc_pkg;

   typedef logic [1:0] acc_mode_t;

   localparam acc_mode_t ACC_ADD  = 2'b00;
   localparam acc_mode_t ACC_SUB  = 2'b01;
   localparam acc_mode_t ACC_LOAD = 2'b10;
   localparam acc_mode_t ACC_HOLD = 2'b11;

endpackage

// File: rtl/acc_alu.sv
// -----------------------------------------------------------------------------
// acc_alu
//   Combinational add/subtract unit for acc_param. Forms the sum or difference
//   of the current accumulator and the zero-extended step in WIDTH+1 bits and
//   resolves out-of-range results by wrapping or saturating.
//
//   Parameters
//     WIDTH    : accumulator width
//     STEP_W   : step operand width (<= WIDTH, zero-extended)
//     SATURATE : 0 = wrap modulo 2^WIDTH, 1 = clamp to 0 / all ones
//   Ports
//     acc    in  : current accumulator value
//     step   in  : unsigned operand
//     mode   in  : operation select (only ADD/SUB change the value here)
//     nxt    out : resulting accumulator value (acc for LOAD/HOLD)
//     ovf_ev out : add carried out of WIDTH bits
//     unf_ev out : subtract borrowed (step > acc)
// -----------------------------------------------------------------------------
import acc_pkg::*;

module acc_alu #(
   parameter int WIDTH    = 6,
   parameter int STEP_W   = WIDTH,
   parameter int SATURATE = 0
) (
   input  logic [WIDTH-1:0]  acc,
   input  logic [STEP_W-1:0] step,
   input  acc_mode_t         mode,
   output logic [WIDTH-1:0]  nxt,
   output logic              ovf_ev,
   output logic              unf_ev
);

   logic [WIDTH:0] acc_x;
   logic [WIDTH:0] step_x;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   // Carry-out of the add: either keep the low bits or pin to the top.
   function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH:0] s);
      if (s[WIDTH] && (SATURATE != 0))
         return '1;
      return s[WIDTH-1:0];
   endfunction

   // Borrow out of the subtract: bit WIDTH of the difference is set exactly
   // when step > acc, so the same bit doubles as the underflow detector.
   function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH:0] d);
      if (d[WIDTH] && (SATURATE != 0))
         return '0;
      return d[WIDTH-1:0];
   endfunction

   assign acc_x  = {1'b0, acc};
   assign step_x = (WIDTH+1)'(step);
   assign sum    = acc_x + step_x;
   assign diff   = acc_x - step_x;

   always_comb begin
      nxt    = acc;
      ovf_ev = 1'b0;
      unf_ev = 1'b0;
      case (mode)
         ACC_ADD: begin
            nxt    = sat_add(sum);
            ovf_ev = sum[WIDTH];
         end
         ACC_SUB: begin
            nxt    = sat_sub(diff);
            unf_ev = diff[WIDTH];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/acc_param.sv
// -----------------------------------------------------------------------------
// acc_param
//   Parametrised accumulator with add / subtract / load / hold, wrap or
//   saturate arithmetic, sticky overflow/underflow flags, a one-cycle event
//   pulse and a snapshot register. All outputs are registered.
//
//   Parameters
//     WIDTH    : accumulator width (>= 2)
//     STEP_W   : width of step and load_val (<= WIDTH, zero-extended)
//     SATURATE : 0 = wrap, 1 = saturate
//   Ports
//     clk      in  : clock, rising edge
//     rst      in  : asynchronous reset, active low
//     en       in  : perform the operation selected by mode
//     mode     in  : 00 add, 01 sub, 10 load, 11 hold
//     step     in  : add/subtract operand
//     load_val in  : value written in load mode
//     clr      in  : synchronous clear of acc and flags (wins over en)
//     snap_req in  : copy the pre-edge acc into snap
//     acc      out : accumulated value
//     snap     out : last captured value
//     ovf      out : sticky overflow
//     unf      out : sticky underflow
//     evt      out : one-cycle pulse after an overflow/underflow edge
// -----------------------------------------------------------------------------
import acc_pkg::*;

module acc_param #(
   parameter int WIDTH    = 6,
   parameter int STEP_W   = WIDTH,
   parameter int SATURATE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  acc_mode_t         mode,
   input  logic [STEP_W-1:0] step,
   input  logic [STEP_W-1:0] load_val,
   input  logic              clr,
   input  logic              snap_req,
   output logic [WIDTH-1:0]  acc,
   output logic [WIDTH-1:0]  snap,
   output logic              ovf,
   output logic              unf,
   output logic              evt
);

   logic [WIDTH-1:0] acc_p1;
   logic [WIDTH-1:0] snap_p1;
   logic             ovf_p1;
   logic             unf_p1;
   logic             evt_p1;

   logic [WIDTH-1:0] alu_nxt_p0;
   logic             alu_ovf_p0;
   logic             alu_unf_p0;

   logic [WIDTH-1:0] acc_p0;
   logic             ovf_p0;
   logic             unf_p0;
   logic             evt_p0;

   acc_alu #(
      .WIDTH    (WIDTH),
      .STEP_W   (STEP_W),
      .SATURATE (SATURATE)
   ) u_alu (
      .acc    (acc_p1),
      .step   (step),
      .mode   (mode),
      .nxt    (alu_nxt_p0),
      .ovf_ev (alu_ovf_p0),
      .unf_ev (alu_unf_p0)
   );

   // ---- stage p0: next-state selection (clr > en > hold) ----
   always_comb begin
      acc_p0 = acc_p1;
      ovf_p0 = ovf_p1;
      unf_p0 = unf_p1;
      evt_p0 = 1'b0;
      if (clr) begin
         acc_p0 = '0;
         ovf_p0 = 1'b0;
         unf_p0 = 1'b0;
      end else if (en) begin
         case (mode)
            ACC_ADD, ACC_SUB: begin
               acc_p0 = alu_nxt_p0;
               ovf_p0 = ovf_p1 | alu_ovf_p0;
               unf_p0 = unf_p1 | alu_unf_p0;
               evt_p0 = alu_ovf_p0 | alu_unf_p0;
            end
            ACC_LOAD: acc_p0 = WIDTH'(load_val);
            default:  ;
         endcase
      end
   end

   // ---- stage p1: registered accumulator, flags and event ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_p1 <= '0;
         ovf_p1 <= 1'b0;
         unf_p1 <= 1'b0;
         evt_p1 <= 1'b0;
      end else begin
         acc_p1 <= acc_p0;
         ovf_p1 <= ovf_p0;
         unf_p1 <= unf_p0;
         evt_p1 <= evt_p0;
      end
   end

   // Snapshot samples the register output, so it always sees the pre-edge
   // value regardless of clr or the operation being committed on that edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         snap_p1 <= '0;
      else if (snap_req)
         snap_p1 <= acc_p1;
   end

   assign acc  = acc_p1;
   assign snap = snap_p1;
   assign ovf  = ovf_p1;
   assign unf  = unf_p1;
   assign evt  = evt_p1;

endmodule

// File: doc/acc_param.md
# acc_param

Parametrised accumulator that succeeds the fixed 6-bit add/subtract accumulator. It adds width and step parameters, a load mode, selectable wrap-or-saturate arithmetic, sticky overflow and underflow flags, and a snapshot register. It sits as a standalone counter/accumulator leaf inside datapath blocks, and a top-level testbench drives it directly.

## Interface
- `WIDTH`, default 6: accumulator width in bits (≥2).
- `STEP_W`, default `WIDTH`: width of the step and load operands (≤`WIDTH`, zero-extended).
- `SATURATE`, default 0: 0 wraps modulo 2^`WIDTH`; 1 clamps to 0 or 2^`WIDTH`−1.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: perform the operation selected by `mode` this cycle.
- `mode` input, 2 bits: 00 add, 01 subtract, 10 load, 11 hold.
- `step` input, `STEP_W` bits: unsigned add/subtract operand.
- `load_val` input, `STEP_W` bits: value written in load mode.
- `clr` input, 1 bit: synchronous clear of the accumulator and flags.
- `snap_req` input, 1 bit: capture the current `acc` into `snap`.
- `acc` output, `WIDTH` bits: accumulated value.
- `snap` output, `WIDTH` bits: last captured value.
- `ovf` output, 1 bit: sticky flag, set when an add exceeds 2^`WIDTH`−1.
- `unf` output, 1 bit: sticky flag, set when a subtract goes below 0.
- `evt` output, 1 bit: one-cycle pulse on any cycle where an overflow or underflow occurred.

## Operation
- All arithmetic is unsigned. `step` is zero-extended to `WIDTH`+1 bits; the sum or difference is formed in `WIDTH`+1 bits.
- Add: overflow when bit `WIDTH` of the sum is 1.
  - `SATURATE`=0: `acc` takes the low `WIDTH` bits.
  - `SATURATE`=1: `acc` becomes all ones.
- Subtract: underflow when `step` > `acc`.
  - `SATURATE`=0: `acc` takes the low `WIDTH` bits (two's-complement wrap).
  - `SATURATE`=1: `acc` becomes 0.
- Load: `acc` takes zero-extended `load_val`. Flags are unchanged and `evt`=0.
- Hold, or `en`=0: `acc` is unchanged and `evt`=0.
- `ovf` and `unf` are sticky. They are set on the event and cleared only by `clr` or reset.
- `evt` is 1 for exactly the cycle after the edge on which the event was registered, in both wrap and saturate modes.
- Priority when inputs coincide:
  - `clr` beats `en`: `acc`, `ovf`, `unf` and `evt` become 0 and the operation is discarded.
  - `snap_req` is independent of `clr`/`en`: `snap` captures the pre-edge `acc`, not the value being computed on that edge.
  - With `snap_req` and `clr` together, `snap` gets the old `acc` and `acc` gets 0.
- A step of 0 is legal: `acc` is unchanged and no event is raised.

## Timing
- Reset: asserting `rst` low immediately forces `acc`=0, `snap`=0, `ovf`=0, `unf`=0 and `evt`=0, independent of `clk`. This also applies mid-operation; any in-flight operation is lost.
- Release: the first operation is taken on the first rising edge with `rst`=1.
- Latency: an operation presented with `en`=1 before edge N is visible on `acc` and the flags after edge N (one cycle). `evt` is registered and aligned with `acc`.
- Back-to-back operations every cycle are supported; no handshake and no stall.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `acc_pkg`:
  - mode encoding constants `ACC_ADD`, `ACC_SUB`, `ACC_LOAD`, `ACC_HOLD`;
  - a 2-bit mode typedef.
- One sub-module, `acc_alu`. It is combinational, parametrised by `WIDTH`, `STEP_W` and `SATURATE`, and takes `acc`, `step` and `mode`. It returns the next value plus `ovf_ev`/`unf_ev`.
- `acc_param` holds all registers and the priority logic (reset > `clr` > `en`).

## Test plan
- Reset with `WIDTH`=6, `SATURATE`=0: drive `rst` low mid-cycle after `acc`=17 → all outputs 0 without waiting for an edge.
- Wrap add: `acc`=60, add `step`=5 → `acc`=1, `ovf`=1, `evt` pulses one cycle, and `ovf` stays 1 through three following hold cycles.
- Saturating subtract (`SATURATE`=1): `acc`=3, sub `step`=7 → `acc`=0, `unf`=1; a further sub of 1 → `acc`=0, `evt` pulses again.
- Load then mixed ops: load 20, add 4 for 4 cycles, sub 8 once → `acc`=20, 24, 28, 32, 36, 28 on successive edges, with no flags set.
- Simultaneous `clr`+`en`+`snap_req` with `acc`=45, add 10 → `acc`=0, `snap`=45, `ovf`=`unf`=0, `evt`=0.
- Parameter sweep at `WIDTH`=16, `STEP_W`=8: add 255 to 65400 → wrap to 119 with `ovf`=1; with `SATURATE`=1 → 65535.
